schmitt_rx_filter: RTL and testbench
====================================

// Module: schmitt_rx_filter
// PURPOSE
//  Digital receiving end of the Schmitt-trigger inverter line: samples a noisy/asynchronous
//  input, applies counter-based hysteresis, and drives a clean level, optionally inverted.
//  Counts output 0->1 transitions as a switching-activity (energy) metric.
//  Sits between an external input line and synchronous logic in the clk domain.
// PARAMETERS
//  CNT_W   4   integrator counter width; CNT_MAX = 2**CNT_W-1
//  TH_HI   12  integrator value at/above which the level becomes HIGH
//  TH_LO   3   integrator value at/below which the level becomes LOW
//  INVERT  1   1: Y = ~level (inverter behaviour); 0: Y = level
//  EV_W    16  width of the rising-transition event counter
//  Legal only if 0 <= TH_LO < TH_HI <= CNT_MAX; otherwise elaboration error.
// PORTS
//  clk        in   1     single clock, all state on posedge
//  reset_L    in   1     synchronous reset, active low
//  enable     in   1     1: integrator/level update; 0: hold
//  A          in   1     asynchronous raw input line
//  cont_clr   in   1     synchronous clear of cont_rise
//  Y          out  1     filtered output level
//  rise_pulse out  1     1-cycle pulse when Y goes 0->1
//  fall_pulse out  1     1-cycle pulse when Y goes 1->0
//  cont_rise  out  EV_W  saturating count of Y 0->1 transitions
// BEHAVIOUR
//  Reset (reset_L=0 at posedge): sync flops=0, cnt=0, level=LOW, Y=INVERT,
//   rise_pulse=0, fall_pulse=0, cont_rise=0. Y value after reset is not a transition.
//  Sync: A -> 2 flops -> a_s (2-cycle latency); runs regardless of enable.
//  Integrator (enable=1): a_s=1 & cnt<CNT_MAX -> cnt+1; a_s=0 & cnt>0 -> cnt-1;
//   else hold. Saturates at 0 and CNT_MAX, never wraps.
//  Level FSM, 2 states, evaluated on registered cnt (enable=1):
//   LOW  -> HIGH when cnt >= TH_HI;  HIGH -> LOW when cnt <= TH_LO; else stay.
//   Values strictly between TH_LO and TH_HI never change level (hysteresis band).
//  Y = level ^ INVERT, driven from the level register (no combinational path from A).
//  Latency, A step after stable opposite level (cnt at 0 or CNT_MAX): posedge
//   TH_HI+3 (rise) / CNT_MAX-TH_LO+3 (fall) after first sampling edge; defaults: 15 / 15.
//  rise_pulse/fall_pulse: registered, asserted exactly the cycle Y shows the new value.
//  cont_rise: +1 per rise_pulse, saturates at 2**EV_W-1 (no wrap).
//   cont_clr=1 has priority: cont_rise <= 0, or 1 if a rise occurs in the same cycle.
//  enable=0: cnt, level, Y hold; pulses 0; sync flops keep sampling; cont_clr still works.
//  Glitch shorter than (TH_HI - cnt) cycles from LOW never changes Y.
//  Reset mid-filtering: everything returns to reset values next edge; no pulse emitted.
// STRUCTURE
//  Shared package schmitt_pkg: default CNT_W/TH_HI/TH_LO/EV_W constants, level encoding
//   localparams LVL_LOW=1'b0, LVL_HIGH=1'b1.
//  One sub-module: sync2_ff (2-flop synchronizer, clk/reset_L, reset value 0).
//  Integrator, level FSM, pulse and event-counter logic in this module.
// TESTING
//  1 Reset: hold reset_L=0 3 cycles with A=1 -> Y=1, cnt=0, pulses 0, cont_rise=0.
//  2 Step A 0->1, held: Y 1->0 at edge 15 after first sampling edge, fall_pulse 1 cycle,
//    cont_rise unchanged; then A 1->0: Y 0->1 after 15 edges, rise_pulse, cont_rise=1.
//  3 Noise: from LOW, A high 8 cycles, low 8, repeated 10x -> Y never changes,
//    no pulses; cnt oscillates within 0..8.
//  4 enable=0 while cnt=10 rising, A=1 for 20 cycles -> Y, cnt frozen; enable=1 ->
//    Y switches 3 edges later (cnt reaches 12, then level edge).
//  5 cont_clr same cycle as rise_pulse -> cont_rise=1; EV_W=4 with 20 rises -> 15.
//  6 reset_L=0 while cnt=9 mid-rise -> cnt=0, Y=INVERT, no pulse; INVERT=0 variant
//    repeats 2 with Y polarity swapped.

Source files
------------

// File: rtl/schmitt_pkg.sv
// Shared constants for the Schmitt-trigger receive filter: default sizing,
// hysteresis thresholds and the level encoding used by the level FSM.
package schmitt_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int TH_HI_DEF = 12;
  localparam int TH_LO_DEF = 3;
  localparam int EV_W_DEF  = 16;

  localparam logic LVL_LOW  = 1'b0;
  localparam logic LVL_HIGH = 1'b1;

  typedef enum logic {
    ST_LOW  = LVL_LOW,
    ST_HIGH = LVL_HIGH
  } level_e;

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchronizer bringing the asynchronous input line into the clk domain.
module sync2_ff (
  input  logic clk,
  input  logic reset_L,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/schmitt_rx_filter.sv
// Receive-side Schmitt filter: synchronizes A, integrates it with a saturating
// counter, applies hysteresis thresholds and counts output rising transitions.
module schmitt_rx_filter
  import schmitt_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TH_HI  = TH_HI_DEF,
  parameter int TH_LO  = TH_LO_DEF,
  parameter bit INVERT = 1'b1,
  parameter int EV_W   = EV_W_DEF
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            enable,
  input  logic            A,
  input  logic            cont_clr,
  output logic            Y,
  output logic            rise_pulse,
  output logic            fall_pulse,
  output logic [EV_W-1:0] cont_rise
);

  localparam int CNT_MAX = 2**CNT_W - 1;
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TH_HI_C   = CNT_W'(TH_HI);
  localparam logic [CNT_W-1:0] TH_LO_C   = CNT_W'(TH_LO);
  localparam logic [EV_W-1:0]  EV_MAX_C  = {EV_W{1'b1}};

  if (!(TH_LO >= 0 && TH_LO < TH_HI && TH_HI <= CNT_MAX)) begin : g_bad_thresholds
    $error("schmitt_rx_filter: thresholds must satisfy 0 <= TH_LO < TH_HI <= 2**CNT_W-1");
  end

  logic             a_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  level_e           level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [EV_W-1:0]  cont_q, cont_d;
  logic             y_cur, y_nxt;

  sync2_ff u_sync (
    .clk     (clk),
    .reset_L (reset_L),
    .d       (A),
    .q       (a_s)
  );

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    cont_d  = cont_q;

    if (enable) begin
      if (a_s && cnt_q != CNT_MAX_C)    cnt_d = cnt_q + CNT_W'(1);
      else if (!a_s && cnt_q != '0)     cnt_d = cnt_q - CNT_W'(1);

      // Thresholds act on the registered count; the band between them holds.
      case (level_q)
        ST_LOW:  if (cnt_q >= TH_HI_C) level_d = ST_HIGH;
        ST_HIGH: if (cnt_q <= TH_LO_C) level_d = ST_LOW;
      endcase
    end

    y_cur  = logic'(level_q) ^ INVERT;
    y_nxt  = logic'(level_d) ^ INVERT;
    rise_d = ~y_cur & y_nxt;
    fall_d = y_cur & ~y_nxt;

    if (cont_clr)                       cont_d = rise_d ? EV_W'(1) : '0;
    else if (rise_d && cont_q != EV_MAX_C) cont_d = cont_q + EV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      cnt_q   <= '0;
      level_q <= ST_LOW;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cont_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cont_q  <= cont_d;
    end
  end

  assign Y          = logic'(level_q) ^ INVERT;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign cont_rise  = cont_q;

endmodule

// File: tb/tb_schmitt_rx_filter.sv
// Directed bench for schmitt_rx_filter: three instances (default, 4-bit event
// counter, non-inverting) share stimulus and are compared each cycle to a model.
module tb_schmitt_rx_filter;

  logic clk = 1'b0;
  logic reset_L, enable, A, cont_clr;

  logic        y_d, rise_d, fall_d;
  logic [15:0] cont_d;
  logic        y_e, rise_e, fall_e;
  logic [3:0]  cont_e;
  logic        y_n, rise_n, fall_n;
  logic [15:0] cont_n;

  always #5 clk = ~clk;

  schmitt_rx_filter dut (
    .clk(clk), .reset_L(reset_L), .enable(enable), .A(A), .cont_clr(cont_clr),
    .Y(y_d), .rise_pulse(rise_d), .fall_pulse(fall_d), .cont_rise(cont_d)
  );

  schmitt_rx_filter #(.EV_W(4)) dut_ev (
    .clk(clk), .reset_L(reset_L), .enable(enable), .A(A), .cont_clr(cont_clr),
    .Y(y_e), .rise_pulse(rise_e), .fall_pulse(fall_e), .cont_rise(cont_e)
  );

  schmitt_rx_filter #(.INVERT(1'b0)) dut_ni (
    .clk(clk), .reset_L(reset_L), .enable(enable), .A(A), .cont_clr(cont_clr),
    .Y(y_n), .rise_pulse(rise_n), .fall_pulse(fall_n), .cont_rise(cont_n)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: A delayed two edges, saturating integrator in 0..15,
  // hysteresis level with thresholds 12/3, saturating event counters.
  int m_cnt, m_c16, m_c4, m_cn;
  bit m_lvl;
  bit m_hist[$];
  bit m_rise_i, m_fall_i, m_rise_n, m_fall_n;

  function automatic int bump(input int c, input bit r, input bit clr, input int mx);
    if (clr) return r ? 1 : 0;
    return (r && c < mx) ? c + 1 : c;
  endfunction

  always @(posedge clk) begin
    bit a_s, nl, rose, fell;
    int nc;
    if (!reset_L) begin
      m_cnt = 0; m_lvl = 1'b0; m_hist = {1'b0, 1'b0};
      m_c16 = 0; m_c4 = 0; m_cn = 0;
      m_rise_i = 0; m_fall_i = 0; m_rise_n = 0; m_fall_n = 0;
    end else begin
      a_s = m_hist[0];
      nc  = m_cnt;
      nl  = m_lvl;
      if (enable) begin
        nc = a_s ? ((m_cnt < 15) ? m_cnt + 1 : 15) : ((m_cnt > 0) ? m_cnt - 1 : 0);
        if (!m_lvl && m_cnt >= 12) nl = 1'b1;
        else if (m_lvl && m_cnt <= 3) nl = 1'b0;
      end
      rose = !m_lvl && nl;
      fell = m_lvl && !nl;
      m_rise_i = fell; m_fall_i = rose;
      m_rise_n = rose; m_fall_n = fell;
      m_c16 = bump(m_c16, fell, cont_clr, 65535);
      m_c4  = bump(m_c4,  fell, cont_clr, 15);
      m_cn  = bump(m_cn,  rose, cont_clr, 65535);
      void'(m_hist.pop_front());
      m_hist.push_back(A);
      m_cnt = nc;
      m_lvl = nl;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_cnt",    dut.cnt_q, m_cnt);
      check("cyc_y",      y_d,    !m_lvl);
      check("cyc_rise",   rise_d, m_rise_i);
      check("cyc_fall",   fall_d, m_fall_i);
      check("cyc_cont",   cont_d, m_c16);
      check("cyc_y_ev",   y_e,    !m_lvl);
      check("cyc_rise_ev", rise_e, m_rise_i);
      check("cyc_fall_ev", fall_e, m_fall_i);
      check("cyc_cont_ev", cont_e, m_c4);
      check("cyc_y_ni",   y_n,    m_lvl);
      check("cyc_rise_ni", rise_n, m_rise_n);
      check("cyc_fall_ni", fall_n, m_fall_n);
      check("cyc_cont_ni", cont_n, m_cn);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Apply a step on A from a settled opposite level; the new Y must appear on
  // edge 15 after the first sampling edge and not one edge earlier.
  task automatic step(input bit a_new);
    A = a_new;
    for (int e = 1; e <= 15; e++) begin
      tick(1);
      if (e == 14) begin
        check("pre_y",    y_d, a_new);
        check("pre_y_ni", y_n, !a_new);
      end
    end
    check("post_y",       y_d,    !a_new);
    check("post_y_ni",    y_n,    a_new);
    check("post_rise",    rise_d, !a_new);
    check("post_fall",    fall_d, a_new);
    check("post_rise_ni", rise_n, a_new);
    check("post_fall_ni", fall_n, !a_new);
  endtask

  initial begin
    reset_L = 1'b0; enable = 1'b1; A = 1'b1; cont_clr = 1'b0;
    tick(3);
    chk_on = 1'b1;
    check("rst_y",    y_d, 1);
    check("rst_cnt",  dut.cnt_q, 0);
    check("rst_rise", rise_d, 0);
    check("rst_fall", fall_d, 0);
    check("rst_cont", cont_d, 0);
    check("rst_y_ni", y_n, 0);

    // Step up then down.
    A = 1'b0; reset_L = 1'b1;
    tick(4);
    step(1'b1);
    check("t2_cont_after_fall", cont_d, 0);
    tick(1);
    check("t2_fall_one_cycle", fall_d, 0);
    tick(5);
    step(1'b0);
    check("t2_cont_after_rise", cont_d, 1);

    // Noise bursts shorter than the threshold.
    tick(20);
    repeat (10) begin
      A = 1'b1; tick(8);
      A = 1'b0; tick(8);
    end
    tick(12);
    check("t3_y_unchanged", y_d, 1);
    check("t3_cont", cont_d, 1);
    check("t3_cnt", dut.cnt_q, 0);

    // Freeze at cnt=10 with enable low.
    A = 1'b1;
    tick(12);
    check("t4_cnt10", dut.cnt_q, 10);
    enable = 1'b0;
    tick(20);
    check("t4_cnt_frozen", dut.cnt_q, 10);
    check("t4_y_frozen", y_d, 1);
    enable = 1'b1;
    tick(2);
    check("t4_y_hold_cnt12", y_d, 1);
    tick(1);
    check("t4_y_switched", y_d, 0);
    check("t4_fall", fall_d, 1);

    // Clear coincident with a rise, then saturation of the 4-bit counter.
    tick(5);
    A = 1'b0;
    tick(14);
    cont_clr = 1'b1;
    tick(1);
    cont_clr = 1'b0;
    check("t5_rise", rise_d, 1);
    check("t5_clr_with_rise", cont_d, 1);
    check("t5_clr_ni", cont_n, 0);
    cont_clr = 1'b1;
    tick(1);
    cont_clr = 1'b0;
    check("t5_clr_plain", cont_d, 0);
    repeat (20) begin
      A = 1'b1; tick(20);
      A = 1'b0; tick(20);
    end
    check("t5_cont16", cont_d, 20);
    check("t5_cont4_sat", cont_e, 15);
    check("t5_cont_ni", cont_n, 20);

    // Reset in the middle of a rise.
    A = 1'b1;
    tick(11);
    check("t6_cnt9", dut.cnt_q, 9);
    reset_L = 1'b0;
    tick(1);
    check("t6_cnt", dut.cnt_q, 0);
    check("t6_y", y_d, 1);
    check("t6_y_ni", y_n, 0);
    check("t6_rise", rise_d, 0);
    check("t6_fall", fall_d, 0);
    check("t6_cont", cont_d, 0);
    reset_L = 1'b1; A = 1'b0;
    tick(4);
    step(1'b1);
    check("t6_cont_ni", cont_n, 1);
    tick(5);
    step(1'b0);

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
